alu_sequencer: RTL and testbench

Multi-cycle operation controller that sits between the instruction decoder and the combinational ALU. It accepts one ALU operation request with a start/busy/done handshake and performs these steps:
- reads the operands from the register file over a synchronous port;
- drives the ALU's mode/a/b/flags inputs;
- writes the result back and commits the flags register.

It owns the flags register. It expands two-step operations into byte sequences: the word operations INCW/DECW and decimal adjust DA.

---
 rtl/alu_sequencer_pkg.sv | 57 +++++
 rtl/alu_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_pkg.sv
`timescale 1ns/1ps
// Shared constants for the ALU sequencer: ALU mode codes, flag bit
// positions, sequencer state encodings and mode classification helpers.
package alu_sequencer_pkg;

  // ALU mode codes. One-operand modes in 0x00..0x06, two-operand at 0x10 up.
  localparam logic [4:0] ALU1_LD   = 5'h00;
  localparam logic [4:0] ALU1_INC  = 5'h01;
  localparam logic [4:0] ALU1_DEC  = 5'h02;
  localparam logic [4:0] ALU1_DA   = 5'h03;
  localparam logic [4:0] ALU1_DA_H = 5'h04;
  localparam logic [4:0] ALU1_INCW = 5'h05;
  localparam logic [4:0] ALU1_DECW = 5'h06;
  localparam logic [4:0] ALU2_ADD  = 5'h10;
  localparam logic [4:0] ALU2_ADC  = 5'h11;
  localparam logic [4:0] ALU2_SUB  = 5'h12;
  localparam logic [4:0] ALU2_SBC  = 5'h13;
  localparam logic [4:0] ALU2_AND  = 5'h14;
  localparam logic [4:0] ALU2_OR   = 5'h15;
  localparam logic [4:0] ALU2_XOR  = 5'h16;
  localparam logic [4:0] ALU2_CP   = 5'h17;
  localparam logic [4:0] ALU2_TM   = 5'h18;
  localparam logic [4:0] ALU2_TCM  = 5'h19;

  // Flag bit positions in the architectural flags register.
  localparam int F_C = 0;
  localparam int F_D = 1;
  localparam int F_V = 2;
  localparam int F_H = 4;
  localparam int F_Z = 6;
  localparam int F_S = 7;

  // Sequencer state encodings.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_A    = 3'd1;
  localparam logic [2:0] ST_RD_B    = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_DA_H    = 3'd4;
  localparam logic [2:0] ST_RD_HI   = 3'd5;
  localparam logic [2:0] ST_EXEC_HI = 3'd6;

  // True exactly for the defined two-operand codes.
  function automatic logic is_two_operand(input logic [4:0] m);
    return (m >= ALU2_ADD) && (m <= ALU2_TCM);
  endfunction

  // Compare/test modes only produce flags.
  function automatic logic no_writeback(input logic [4:0] m);
    return (m == ALU2_CP) || (m == ALU2_TM) || (m == ALU2_TCM);
  endfunction

  // Word increment/decrement on an even/odd register pair.
  function automatic logic is_word_op(input logic [4:0] m);
    return (m == ALU1_INCW) || (m == ALU1_DECW);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
`timescale 1ns/1ps
// alu_sequencer: multi-cycle controller between the instruction decoder and
// the combinational ALU. Reads operands, drives the ALU, writes results back
// and owns the flags register. DA and INCW/DECW run as two byte steps.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] mode,
  input  logic [7:0] dst,
  input  logic [7:0] src,
  input  logic       srcImm,
  output logic       busy,
  output logic       done,
  output logic [7:0] regAddr,
  output logic       regRe,
  input  logic [7:0] regRdData,
  output logic       regWe,
  output logic [7:0] regWrData,
  output logic [4:0] aluMode,
  output logic [7:0] aluA,
  output logic [7:0] aluB,
  output logic [7:0] aluFlags,
  input  logic [7:0] aluOut,
  input  logic [7:0] aluOutFlags,
  output logic [7:0] flags,
  input  logic       flagsWr,
  input  logic [7:0] flagsWrData
);

  logic [2:0] state;
  logic [4:0] mode_q;
  logic [7:0] dst_q;
  logic [7:0] src_q;
  logic       imm_q;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [7:0] tmp_flags;
  logic [7:0] flags_q;

  logic       reg_src;
  logic       word_op;
  logic       da_op;
  logic [7:0] dst_lo;
  logic [7:0] dst_hi;

  assign reg_src = is_two_operand(mode_q) && !imm_q;
  assign word_op = is_word_op(mode_q);
  assign da_op   = (mode_q == ALU1_DA);
  assign dst_lo  = dst_q | 8'h01;
  assign dst_hi  = dst_q & 8'hFE;
  assign busy    = (state != ST_IDLE);
  assign flags   = flags_q;

  // Per-state strobes and ALU drive; everything idles at zero / ALU1_LD.
  always_comb begin
    done      = 1'b0;
    regAddr   = 8'h00;
    regRe     = 1'b0;
    regWe     = 1'b0;
    regWrData = 8'h00;
    aluMode   = ALU1_LD;
    aluA      = 8'h00;
    aluB      = 8'h00;
    aluFlags  = 8'h00;
    case (state)
      ST_RD_A: begin
        regRe   = 1'b1;
        regAddr = word_op ? dst_lo : dst_q;
      end
      ST_RD_B: begin
        if (reg_src) begin
          regRe   = 1'b1;
          regAddr = src_q;
        end
      end
      ST_EXEC: begin
        aluA     = op_a;
        aluB     = reg_src ? regRdData : op_b;
        aluFlags = flags_q;
        if (da_op) begin
          aluMode = ALU1_DA;
        end else if (word_op) begin
          aluMode   = (mode_q == ALU1_INCW) ? ALU1_INC : ALU1_DEC;
          regWe     = 1'b1;
          regAddr   = dst_lo;
          regWrData = aluOut;
        end else begin
          aluMode = mode_q;
          done    = 1'b1;
          if (!no_writeback(mode_q)) begin
            regWe     = 1'b1;
            regAddr   = dst_q;
            regWrData = aluOut;
          end
        end
      end
      ST_DA_H: begin
        aluMode   = ALU1_DA_H;
        aluA      = op_a;
        aluFlags  = tmp_flags;
        regWe     = 1'b1;
        regAddr   = dst_q;
        regWrData = aluOut;
        done      = 1'b1;
      end
      ST_RD_HI: begin
        regRe   = 1'b1;
        regAddr = dst_hi;
      end
      ST_EXEC_HI: begin
        aluMode   = mode_q;
        aluA      = regRdData;
        aluB      = op_b;
        aluFlags  = tmp_flags;
        regWe     = 1'b1;
        regAddr   = dst_hi;
        regWrData = aluOut;
        done      = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State sequencing, operand capture and flag commit in the final step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      mode_q    <= ALU1_LD;
      dst_q     <= 8'h00;
      src_q     <= 8'h00;
      imm_q     <= 1'b0;
      op_a      <= 8'h00;
      op_b      <= 8'h00;
      tmp_flags <= 8'h00;
      flags_q   <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (flagsWr) flags_q <= flagsWrData;
          if (start) begin
            mode_q <= mode;
            dst_q  <= dst;
            src_q  <= src;
            imm_q  <= srcImm;
            state  <= ST_RD_A;
          end
        end
        ST_RD_A: state <= ST_RD_B;
        ST_RD_B: begin
          op_a <= regRdData;
          if (imm_q) op_b <= src_q;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (da_op) begin
            op_a      <= aluOut;
            tmp_flags <= aluOutFlags;
            state     <= ST_DA_H;
          end else if (word_op) begin
            op_b      <= aluOut;
            tmp_flags <= aluOutFlags;
            state     <= ST_RD_HI;
          end else begin
            flags_q <= aluOutFlags;
            state   <= ST_IDLE;
          end
        end
        ST_DA_H: begin
          flags_q <= aluOutFlags;
          state   <= ST_IDLE;
        end
        ST_RD_HI: state <= ST_EXEC_HI;
        ST_EXEC_HI: begin
          flags_q <= aluOutFlags;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
// Bench for alu_sequencer: behavioural ALU and register file around the DUT,
// scoreboard of expected writes and done pulses with their cycle numbers.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic       clk;
  logic       reset;
  logic       start;
  logic [4:0] mode;
  logic [7:0] dst;
  logic [7:0] src;
  logic       srcImm;
  logic       busy;
  logic       done;
  logic [7:0] regAddr;
  logic       regRe;
  logic [7:0] regRdData;
  logic       regWe;
  logic [7:0] regWrData;
  logic [4:0] aluMode;
  logic [7:0] aluA;
  logic [7:0] aluB;
  logic [7:0] aluFlags;
  logic [7:0] aluOut;
  logic [7:0] aluOutFlags;
  logic [7:0] flags;
  logic       flagsWr;
  logic [7:0] flagsWrData;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .dst(dst),
    .src(src), .srcImm(srcImm), .busy(busy), .done(done),
    .regAddr(regAddr), .regRe(regRe), .regRdData(regRdData),
    .regWe(regWe), .regWrData(regWrData), .aluMode(aluMode),
    .aluA(aluA), .aluB(aluB), .aluFlags(aluFlags), .aluOut(aluOut),
    .aluOutFlags(aluOutFlags), .flags(flags), .flagsWr(flagsWr),
    .flagsWrData(flagsWrData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: returns {flags, result}.
  function automatic logic [15:0] alu_f(input logic [4:0] m, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] f);
    logic [8:0] s;
    logic [7:0] r;
    logic [7:0] fo;
    logic       cin;
    logic       upd;
    s = 9'h000; r = 8'h00; fo = f; cin = 1'b0; upd = 1'b1;
    case (m)
      ALU2_ADD, ALU2_ADC: begin
        cin = (m == ALU2_ADC) ? f[F_C] : 1'b0;
        s = {1'b0, a} + {1'b0, b} + {8'h00, cin};
        r = s[7:0];
        fo[F_C] = s[8];
        fo[F_H] = ({1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'h0, cin}) > 5'd15;
        fo[F_V] = (a[7] == b[7]) && (r[7] != a[7]);
        fo[F_D] = 1'b0;
      end
      ALU2_SUB, ALU2_SBC, ALU2_CP: begin
        cin = (m == ALU2_SBC) ? f[F_C] : 1'b0;
        s = {1'b0, a} - {1'b0, b} - {8'h00, cin};
        r = s[7:0];
        fo[F_C] = s[8];
        fo[F_H] = {1'b0, a[3:0]} < ({1'b0, b[3:0]} + {4'h0, cin});
        fo[F_V] = (a[7] != b[7]) && (r[7] != a[7]);
        fo[F_D] = 1'b1;
      end
      ALU2_AND, ALU2_TM: begin r = a & b;  fo[F_V] = 1'b0; end
      ALU2_OR:           begin r = a | b;  fo[F_V] = 1'b0; end
      ALU2_XOR:          begin r = a ^ b;  fo[F_V] = 1'b0; end
      ALU2_TCM:          begin r = ~a & b; fo[F_V] = 1'b0; end
      ALU1_INC: begin
        r = a + 8'h01; fo[F_V] = (a == 8'h7F); fo[F_H] = (a[3:0] == 4'hF); fo[F_D] = 1'b0;
      end
      ALU1_DEC: begin
        r = a - 8'h01; fo[F_V] = (a == 8'h80); fo[F_H] = (a[3:0] == 4'h0); fo[F_D] = 1'b1;
      end
      ALU1_INCW: begin
        r = a + {7'h00, (b == 8'h00)}; fo[F_V] = (a == 8'h7F) && (b == 8'h00);
      end
      ALU1_DECW: begin
        r = a - {7'h00, (b == 8'hFF)}; fo[F_V] = (a == 8'h80) && (b == 8'hFF);
      end
      ALU1_DA: begin
        r = a;
        if (f[F_H] || (a[3:0] > 4'd9)) begin
          if (f[F_D]) r = a - 8'h06;
          else begin
            s = {1'b0, a} + 9'h006; r = s[7:0]; fo[F_C] = f[F_C] | s[8];
          end
        end
        fo[F_H] = 1'b0;
      end
      ALU1_DA_H: begin
        r = a;
        if (f[F_C] || (a[7:4] > 4'd9)) begin
          r = f[F_D] ? (a - 8'h60) : (a + 8'h60);
          fo[F_C] = 1'b1;
        end
      end
      default: begin r = b; upd = 1'b0; end
    endcase
    if (upd) begin
      fo[F_S] = r[7];
      if ((m == ALU1_INCW) || (m == ALU1_DECW)) fo[F_Z] = (r == 8'h00) && (b == 8'h00);
      else fo[F_Z] = (r == 8'h00);
    end
    return {fo, r};
  endfunction

  logic [15:0] alu_res;
  assign alu_res     = alu_f(aluMode, aluA, aluB, aluFlags);
  assign aluOut      = alu_res[7:0];
  assign aluOutFlags = alu_res[15:8];

  // Register file with synchronous read and a bench-side preload port.
  logic [7:0] mem [256];
  logic [7:0] rd_q;
  logic       pl_en;
  logic [7:0] pl_addr;
  logic [7:0] pl_data;
  assign regRdData = rd_q;
  always @(posedge clk) begin
    if (regWe) mem[regAddr] <= regWrData;
    if (pl_en) mem[pl_addr] <= pl_data;
    if (regRe) rd_q <= mem[regAddr];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t wq[$];
  int  dq[$];
  logic [7:0] model_flags = 8'h00;

  // Scoreboard monitor: every write and done pulse must match an expectation.
  ev_t we_ev;
  int  dn_cyc;
  always @(negedge clk) begin
    if (regWe) begin
      if (wq.size() == 0) check_val("unexpected_write", {31'd0, regWe}, 32'd0);
      else begin
        we_ev = wq.pop_front();
        check_val("write_cycle", cyc, we_ev.cyc);
        check_val("write_addr", {24'd0, regAddr}, {24'd0, we_ev.addr});
        check_val("write_data", {24'd0, regWrData}, {24'd0, we_ev.data});
      end
    end
    if (done) begin
      if (dq.size() == 0) check_val("unexpected_done", {31'd0, done}, 32'd0);
      else begin
        dn_cyc = dq.pop_front();
        check_val("done_cycle", cyc, dn_cyc);
      end
    end
  end

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic load_flags(input logic [7:0] d);
    flagsWr = 1'b1; flagsWrData = d;
    @(negedge clk);
    flagsWr = 1'b0;
    model_flags = d;
  endtask

  // Predict the operation's effects, then pulse start for one cycle.
  task automatic launch(input logic [4:0] m, input logic [7:0] d, input logic [7:0] s,
                        input logic imm);
    int c;
    logic [7:0]  b;
    logic [15:0] r1;
    logic [15:0] r2;
    c = cyc;
    b = imm ? s : mem[s];
    if (is_word_op(m)) begin
      r1 = alu_f((m == ALU1_INCW) ? ALU1_INC : ALU1_DEC, mem[d | 8'h01], 8'h00, model_flags);
      wq.push_back('{c + 3, d | 8'h01, r1[7:0]});
      r2 = alu_f(m, mem[d & 8'hFE], r1[7:0], r1[15:8]);
      wq.push_back('{c + 5, d & 8'hFE, r2[7:0]});
      dq.push_back(c + 5);
      model_flags = r2[15:8];
    end else if (m == ALU1_DA) begin
      r1 = alu_f(ALU1_DA, mem[d], 8'h00, model_flags);
      r2 = alu_f(ALU1_DA_H, r1[7:0], 8'h00, r1[15:8]);
      wq.push_back('{c + 4, d, r2[7:0]});
      dq.push_back(c + 4);
      model_flags = r2[15:8];
    end else begin
      r1 = alu_f(m, mem[d], b, model_flags);
      if (!no_writeback(m)) wq.push_back('{c + 3, d, r1[7:0]});
      dq.push_back(c + 3);
      model_flags = r1[15:8];
    end
    mode = m; dst = d; src = s; srcImm = imm; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int pending;
    for (int i = 0; i < 20; i++) begin
      if (!busy && (dq.size() == 0)) break;
      @(negedge clk);
    end
    pending = (busy || (dq.size() != 0) || (wq.size() != 0)) ? 1 : 0;
    check_val("op_completes", pending, 0);
  endtask

  task automatic run_op(input logic [4:0] m, input logic [7:0] d, input logic [7:0] s,
                        input logic imm);
    launch(m, d, s, imm);
    wait_idle();
    check_val("flags_after_op", {24'd0, flags}, {24'd0, model_flags});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [4:0] mtab [15];
  logic [7:0] pre_flags;
  logic [4:0] rm;
  logic [7:0] rd;

  initial begin
    mtab = '{ALU2_ADD, ALU2_ADC, ALU2_SUB, ALU2_SBC, ALU2_AND, ALU2_OR, ALU2_XOR,
             ALU2_CP, ALU2_TM, ALU2_TCM, ALU1_INC, ALU1_DEC, ALU1_DA, ALU1_INCW, ALU1_DECW};
    reset = 1'b1; start = 1'b0; mode = 5'h00; dst = 8'h00; src = 8'h00; srcImm = 1'b0;
    flagsWr = 1'b0; flagsWrData = 8'h00; pl_en = 1'b0; pl_addr = 8'h00; pl_data = 8'h00;
    @(negedge clk);
    for (int i = 0; i < 48; i++) preload(i[7:0], 8'($urandom));

    // Reset values
    check_val("rst_busy", {31'd0, busy}, 0);
    check_val("rst_done", {31'd0, done}, 0);
    check_val("rst_regRe", {31'd0, regRe}, 0);
    check_val("rst_regWe", {31'd0, regWe}, 0);
    check_val("rst_flags", {24'd0, flags}, 0);
    check_val("rst_aluMode", {27'd0, aluMode}, {27'd0, ALU1_LD});
    check_val("rst_regAddr", {24'd0, regAddr}, 0);
    reset = 1'b0;
    @(negedge clk);

    // External flags load in IDLE
    load_flags(8'h80);
    check_val("flagswr_idle", {24'd0, flags}, 32'h80);

    // ADD r10 = 3A + C6
    preload(8'd10, 8'h3A); preload(8'd11, 8'hC6);
    run_op(ALU2_ADD, 8'd10, 8'd11, 1'b0);
    check_val("add_result", {24'd0, mem[10]}, 32'h00);
    check_val("add_C", {31'd0, flags[F_C]}, 1);
    check_val("add_Z", {31'd0, flags[F_Z]}, 1);
    check_val("add_H", {31'd0, flags[F_H]}, 1);
    check_val("add_V", {31'd0, flags[F_V]}, 0);
    check_val("add_S", {31'd0, flags[F_S]}, 0);

    // INCW on pair r20/r21 = 12/FF with carry preset
    load_flags(8'h01);
    preload(8'd20, 8'h12); preload(8'd21, 8'hFF);
    run_op(ALU1_INCW, 8'd20, 8'd0, 1'b0);
    check_val("incw_lo", {24'd0, mem[21]}, 32'h00);
    check_val("incw_hi", {24'd0, mem[20]}, 32'h13);
    check_val("incw_Z", {31'd0, flags[F_Z]}, 0);
    check_val("incw_S", {31'd0, flags[F_S]}, 0);
    check_val("incw_C", {31'd0, flags[F_C]}, 1);

    // Decimal adjust of 3C with D=H=C=0
    load_flags(8'h00);
    preload(8'd5, 8'h3C);
    run_op(ALU1_DA, 8'd5, 8'd0, 1'b0);
    check_val("da_result", {24'd0, mem[5]}, 32'h42);
    check_val("da_C", {31'd0, flags[F_C]}, 0);

    // CP r1 (05) against immediate 07
    preload(8'd1, 8'h05);
    run_op(ALU2_CP, 8'd1, 8'h07, 1'b1);
    check_val("cp_C", {31'd0, flags[F_C]}, 1);
    check_val("cp_S", {31'd0, flags[F_S]}, 1);
    check_val("cp_Z", {31'd0, flags[F_Z]}, 0);
    check_val("cp_no_write", {24'd0, mem[1]}, 32'h05);

    // Handshake: start and flagsWr while busy are both dropped
    pre_flags = flags;
    launch(ALU2_SUB, 8'd12, 8'd13, 1'b0);
    check_val("busy_rd_a", {31'd0, busy}, 1);
    mode = ALU2_XOR; dst = 8'd14; src = 8'd15; start = 1'b1;
    flagsWr = 1'b1; flagsWrData = 8'hFF;
    @(negedge clk);
    start = 1'b0; flagsWr = 1'b0;
    check_val("flagswr_busy", {24'd0, flags}, {24'd0, pre_flags});
    wait_idle();
    check_val("flags_after_sub", {24'd0, flags}, {24'd0, model_flags});
    repeat (6) @(negedge clk);
    check_val("no_extra_op", {31'd0, busy}, 0);

    // Reset during RD_HI of an INCW on pair r30/r31 = 55/FF
    preload(8'd30, 8'h55); preload(8'd31, 8'hFF);
    launch(ALU1_INCW, 8'd30, 8'd0, 1'b0);
    repeat (3) @(negedge clk);
    check_val("rdhi_regRe", {31'd0, regRe}, 1);
    check_val("rdhi_regAddr", {24'd0, regAddr}, 32'd30);
    reset = 1'b1;
    wq.delete(); dq.delete();
    @(negedge clk);
    check_val("midrst_busy", {31'd0, busy}, 0);
    check_val("midrst_regWe", {31'd0, regWe}, 0);
    check_val("midrst_flags", {24'd0, flags}, 0);
    reset = 1'b0;
    model_flags = 8'h00;
    @(negedge clk);
    check_val("midrst_lo_kept", {24'd0, mem[31]}, 32'h00);
    check_val("midrst_hi_untouched", {24'd0, mem[30]}, 32'h55);
    preload(8'd2, 8'h10);
    run_op(ALU2_ADD, 8'd2, 8'h25, 1'b1);
    check_val("fresh_add", {24'd0, mem[2]}, 32'h35);

    // Random mix of operations against the model
    for (int i = 0; i < 24; i++) begin
      rm = mtab[$urandom_range(0, 14)];
      rd = 8'($urandom_range(0, 47));
      if (is_word_op(rm)) rd = rd & 8'hFE;
      run_op(rm, rd, 8'($urandom_range(0, 47)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
